// File: rtl/aes_pkg.sv
// Purpose: shared AES-128 key-schedule constants, Rcon table and controller state encoding.
// Latency: none (declarations only).
// Backpressure: not applicable.
package aes_pkg;

  localparam int AES_KEY_LEN    = 128;
  localparam int AES_WORD_LEN   = 32;
  localparam int AES_NUM_ROUNDS = 10;

  // Entry [r] is the round constant for round r; entry 0 is unused by the schedule.
  localparam logic [10:0][7:0] AES_RCON = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } ks_state_t;

endpackage

// File: rtl/aes_sbox_word.sv
// Purpose: AES SubWord, four parallel byte S-boxes (GF(2^8) inverse followed by the affine map).
// Latency: purely combinational.
// Backpressure: none; output follows input.
module aes_sbox_word (
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse is x^254 (maps 0 to 0), then the fixed affine transform with constant 0x63.
  function automatic logic [7:0] sbox_byte(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Substitute each byte of the word independently.
  always_comb begin
    word_out = '0;
    for (int i = 0; i < 4; i++) begin
      word_out[8*i +: 8] = sbox_byte(word_in[8*i +: 8]);
    end
  end

endmodule

// File: rtl/key_schedule_ctrl.sv
// Purpose: AES-128 key expansion controller with 11-entry round-key store and read port.
// Latency: 10 cycles from key acceptance to keys_ready; round-key reads return 1 cycle after request.
// Backpressure: key_ready low during expansion (key_valid ignored); reads never stall, invalid reads drop.
module key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int KEY_LEN    = AES_KEY_LEN,
  parameter int WORD_LEN   = AES_WORD_LEN,
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [KEY_LEN-1:0] key_in,
  input  logic               key_valid,
  output logic               key_ready,
  input  logic               rd_en,
  input  logic [3:0]         rd_round,
  output logic [KEY_LEN-1:0] rd_key,
  output logic               rd_valid,
  output logic               keys_ready,
  output logic               busy
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  ks_state_t          state_q;
  logic [3:0]         cnt_q;
  logic [KEY_LEN-1:0] work_q;
  logic [KEY_LEN-1:0] slot_q [0:NUM_ROUNDS];

  logic                accept;
  logic                rd_hit;
  logic [WORD_LEN-1:0] w0, w1, w2, w3;
  logic [WORD_LEN-1:0] n0, n1, n2, n3;
  logic [WORD_LEN-1:0] sub_rot;
  logic [KEY_LEN-1:0]  next_key;

  assign accept = key_valid && (state_q != EXPAND);
  assign rd_hit = rd_en && keys_ready && (rd_round <= LAST_ROUND);

  assign w0 = work_q[KEY_LEN-1            -: WORD_LEN];
  assign w1 = work_q[KEY_LEN-1-WORD_LEN   -: WORD_LEN];
  assign w2 = work_q[KEY_LEN-1-2*WORD_LEN -: WORD_LEN];
  assign w3 = work_q[WORD_LEN-1:0];

  aes_sbox_word u_sbox (
    .word_in  ({w3[WORD_LEN-9:0], w3[WORD_LEN-1 -: 8]}),
    .word_out (sub_rot)
  );

  // Next round key from the current working key.
  always_comb begin
    n0       = w0 ^ sub_rot ^ {AES_RCON[cnt_q], 24'h000000};
    n1       = w1 ^ n0;
    n2       = w2 ^ n1;
    n3       = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  // Control FSM: accept a key, expand one round per cycle, then hold results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      key_ready  <= 1'b1;
      busy       <= 1'b0;
      keys_ready <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (key_valid) begin
            state_q    <= EXPAND;
            cnt_q      <= 4'd1;
            key_ready  <= 1'b0;
            busy       <= 1'b1;
            keys_ready <= 1'b0;
          end
        end
        EXPAND: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LAST_ROUND) begin
            state_q    <= DONE;
            key_ready  <= 1'b1;
            busy       <= 1'b0;
            keys_ready <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          key_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Key storage and working register; contents are only meaningful once keys_ready is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      slot_q[0] <= key_in;
      work_q    <= key_in;
    end else if (state_q == EXPAND) begin
      slot_q[cnt_q] <= next_key;
      work_q        <= next_key;
    end
  end

  // Read port: registered lookup, old key set is seen on an edge that also accepts a new key.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_key   <= '0;
    end else begin
      rd_valid <= rd_hit;
      if (rd_hit) rd_key <= slot_q[rd_round];
    end
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
module tb_key_schedule_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic         rd_en = 1'b0;
  logic [3:0]   rd_round = 4'd0;
  logic [127:0] rd_key;
  logic         rd_valid;
  logic         keys_ready;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n;

  localparam logic [127:0] K_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_OTHER = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] F_R1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] F_R10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_R1    = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_R10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  key_schedule_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .rd_en      (rd_en),
    .rd_round   (rd_round),
    .rd_key     (rd_key),
    .rd_valid   (rd_valid),
    .keys_ready (keys_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Standard AES forward S-box, row-major.
  logic [0:255][7:0] sbox_t = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [127:0] m_set  [11];
  logic [127:0] m_pend [11];
  bit           m_busy  = 0;
  bit           m_ready = 0;
  bit           m_rdv   = 0;
  logic [127:0] m_rdkey = '0;
  int           m_left  = 0;

  // Textbook word-oriented AES-128 key expansion into m_pend.
  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) m_pend[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_busy = 0; m_ready = 0; m_rdv = 0; m_rdkey = '0;
    end else begin
      if (rd_en && m_ready && rd_round <= 4'd10) begin
        m_rdv = 1; m_rdkey = m_set[rd_round];
      end else begin
        m_rdv = 0;
      end
      if (!m_busy && key_valid) begin
        expand(key_in);
        m_busy = 1; m_left = 10; m_ready = 0;
      end else if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_ready = 1;
          for (int r = 0; r < 11; r++) m_set[r] = m_pend[r];
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("busy", {127'd0, busy}, {127'd0, m_busy});
    chk("key_ready", {127'd0, key_ready}, {127'd0, !m_busy});
    chk("keys_ready", {127'd0, keys_ready}, {127'd0, m_ready});
    chk("rd_valid", {127'd0, rd_valid}, {127'd0, m_rdv});
    chk("rd_key", rd_key, m_rdkey);
  end

  // ---------------- directed stimulus ----------------
  task automatic do_read(input logic [3:0] r);
    rd_en = 1'b1; rd_round = r;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic accept_key(input logic [127:0] k);
    key_valid = 1'b1; key_in = k;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  // Called just after the accepting edge; counts edges until keys_ready.
  task automatic wait_keys(input string name);
    int c;
    c = 0;
    while (keys_ready !== 1'b1 && c < 40) begin
      @(posedge clk); #1; c++;
    end
    chk(name, 128'(c), 128'd10);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_key_ready", {127'd0, key_ready}, 128'd1);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_keys_ready", {127'd0, keys_ready}, 128'd0);
    chk("rst_rd_valid", {127'd0, rd_valid}, 128'd0);
    chk("rst_rd_key", rd_key, 128'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // FIPS key, with a read and a competing key pulse mid-expansion.
    accept_key(K_FIPS);
    n = 0;
    while (keys_ready !== 1'b1 && n < 40) begin
      if (n == 3) begin rd_en = 1; rd_round = 4'd1; key_valid = 1; key_in = K_OTHER; end
      else begin rd_en = 0; key_valid = 0; end
      @(posedge clk); #1; n++;
      if (n == 4) chk("rd_during_expand", {127'd0, rd_valid}, 128'd0);
    end
    rd_en = 0; key_valid = 0;
    chk("fips_ready_latency", 128'(n), 128'd10);
    do_read(4'd1);
    chk("fips_r1", rd_key, F_R1);
    do_read(4'd10);
    chk("fips_r10", rd_key, F_R10);
    do_read(4'd11);
    chk("rd11_valid", {127'd0, rd_valid}, 128'd0);
    chk("rd11_hold", rd_key, F_R10);
    do_read(4'd15);
    chk("rd15_valid", {127'd0, rd_valid}, 128'd0);
    chk("rd15_hold", rd_key, F_R10);
    do_read(4'd0);
    chk("fips_r0", rd_key, K_FIPS);

    // Back-to-back reads.
    rd_en = 1; rd_round = 4'd5;
    @(posedge clk); #1;
    rd_round = 4'd9;
    @(posedge clk); #1;
    rd_en = 0;
    repeat (2) @(posedge clk);
    #1;

    // All-zero key.
    accept_key('0);
    wait_keys("zero_ready_latency");
    do_read(4'd1);
    chk("zero_r1", rd_key, Z_R1);
    do_read(4'd10);
    chk("zero_r10", rd_key, Z_R10);
    do_read(4'd0);
    chk("zero_r0", rd_key, 128'd0);

    // Reset in the middle of an expansion.
    accept_key(K_FIPS);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", {127'd0, busy}, 128'd0);
    chk("abort_keys_ready", {127'd0, keys_ready}, 128'd0);
    chk("abort_rd_valid", {127'd0, rd_valid}, 128'd0);
    @(negedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_still_not_ready", {127'd0, keys_ready}, 128'd0);
    accept_key(K_FIPS);
    wait_keys("abort_ready_latency");
    do_read(4'd10);
    chk("abort_r10", rd_key, F_R10);

    // New key accepted in DONE together with a read of round 10.
    key_valid = 1; key_in = '0; rd_en = 1; rd_round = 4'd10;
    @(posedge clk); #1;
    key_valid = 0; rd_en = 0;
    chk("swap_rd_valid", {127'd0, rd_valid}, 128'd1);
    chk("swap_old_r10", rd_key, F_R10);
    chk("swap_keys_ready_drop", {127'd0, keys_ready}, 128'd0);
    wait_keys("swap_ready_latency");
    do_read(4'd10);
    chk("swap_new_r10", rd_key, Z_R10);

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
